// File: rtl/fns_pkg.sv
// Shared definitions for the Zeckendorf (Fibonacci numeral system) encoder:
// widths, the controller state enum and the weight function w(k).
package fns_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;
  localparam int FNS_W  = DATA_W + 1;
  localparam int K_W    = $clog2(CODE_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_ENC  = 2'd2,
    ST_DONE = 2'd3
  } fns_state_t;

  // w(0)=1, w(1)=2, w(k)=w(k-1)+w(k-2)
  function automatic int fns_weight(input int k);
    int lo;
    int hi;
    int nxt;
    lo = 1;
    hi = 2;
    if (k == 0) return 1;
    for (int i = 1; i < k; i++) begin
      nxt = lo + hi;
      lo  = hi;
      hi  = nxt;
    end
    return hi;
  endfunction

  // The codeword must be able to represent every data value, and the top
  // weight generated during GEN must fit the FNS_W-bit step adder.
  localparam bit FNS_COVERS_RANGE = fns_weight(CODE_W) > ((2 ** DATA_W) - 1);
  localparam bit FNS_TOP_FITS     = fns_weight(CODE_W - 1) < (2 ** (DATA_W + 1));
  localparam bit FNS_PARAMS_OK    = FNS_COVERS_RANGE && FNS_TOP_FITS;

endpackage

// File: rtl/fib_step_adder.sv
// Shared Fibonacci step adder: walks the weight pair up (a+b) or down (b-a).
module fib_step_adder
  import fns_pkg::*;
(
  input  logic [FNS_W-1:0] a,
  input  logic [FNS_W-1:0] b,
  input  logic             mode,
  output logic [FNS_W-1:0] y
);

  // mode 0 generates the next weight, mode 1 recovers the previous one
  always_comb begin
    y = mode ? (b - a) : (a + b);
  end

endmodule

// File: rtl/fns_encode_ctrl.sv
// Sequential Zeckendorf encoder controller. GEN walks the weight pair up to
// w(CODE_W-1); ENC walks it back down, greedily subtracting each weight from
// the residual and setting the matching codeword bit. err_in bypasses the
// encoder and forwards the raw word with err_out set.
module fns_encode_ctrl
  import fns_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              err_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] code_out,
  output logic              err_out,
  output logic              busy
);

  fns_state_t        state_reg, state_next;
  logic [FNS_W-1:0]  a_reg, a_next;
  logic [FNS_W-1:0]  b_reg, b_next;
  logic [FNS_W-1:0]  r_reg, r_next;
  logic [K_W-1:0]    k_reg, k_next;
  logic [CODE_W-1:0] code_reg, code_next;
  logic              err_reg, err_next;
  logic              out_valid_reg;

  logic [FNS_W-1:0]  step_y;
  logic              step_sub;
  logic              take;

  // Single shared adder: add while generating, subtract while encoding
  assign step_sub = (state_reg == ST_ENC);

  fib_step_adder u_step (
    .a    (a_reg),
    .b    (b_reg),
    .mode (step_sub),
    .y    (step_y)
  );

  // Residual comparator is independent of the step adder
  assign take = (r_reg >= b_reg);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      r_reg         <= '0;
      k_reg         <= '0;
      code_reg      <= '0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      r_reg         <= r_next;
      k_reg         <= k_next;
      code_reg      <= code_next;
      err_reg       <= err_next;
      out_valid_reg <= (state_next == ST_DONE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    r_next     = r_reg;
    k_next     = k_reg;
    code_next  = code_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          if (err_in) begin
            code_next  = {{(CODE_W-DATA_W){1'b0}}, data_in};
            err_next   = 1'b1;
            state_next = ST_DONE;
          end else begin
            r_next     = {1'b0, data_in};
            a_next     = FNS_W'(1);
            b_next     = FNS_W'(2);
            k_next     = K_W'(1);
            code_next  = '0;
            err_next   = 1'b0;
            state_next = ST_GEN;
          end
        end
      end
      ST_GEN: begin
        // Invariant: b = w(k), a = w(k-1)
        a_next = b_reg;
        b_next = step_y;
        k_next = k_reg + K_W'(1);
        if (k_reg == K_W'(CODE_W - 2)) state_next = ST_ENC;
      end
      ST_ENC: begin
        if (take) begin
          code_next[k_reg] = 1'b1;
          r_next           = r_reg - b_reg;
        end
        // At k=0 the step result is unused; the walk ends here
        b_next = a_reg;
        a_next = step_y;
        k_next = k_reg - K_W'(1);
        if (k_reg == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg == ST_GEN) || (state_reg == ST_ENC);
  assign out_valid = out_valid_reg;
  assign code_out  = code_reg;
  assign err_out   = err_reg;

  // A finished encode must have consumed the whole residual; a non-zero
  // residual means the weight set cannot cover the data range.
  assert property (@(posedge clk) disable iff (rst)
    (state_reg == ST_DONE && !err_reg) |-> (r_reg == '0 && FNS_PARAMS_OK));

endmodule

// File: tb/tb_fns_encode_ctrl.sv
// Testbench for fns_encode_ctrl: vector table, exhaustive sweep, hold and
// mid-operation reset sequences, with a scoreboard queue of expected words.
module tb_fns_encode_ctrl;
  import fns_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              err_in;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] code_out;
  logic              err_out;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  localparam int W_TAB [12] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
  localparam int LAT_ENC = 22;
  localparam int LAT_BYP = 0;

  typedef struct {
    logic [7:0]  data;
    logic        err;
    logic [11:0] code;
    logic        exp_err;
    bit          exact;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[14];

  fns_encode_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .err_in    (err_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code_out  (code_out),
    .err_out   (err_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each handshaken codeword against the queued expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=0x%0h required=none", code_out);
      end else begin
        vec_t e;
        int   sum;
        e = sb.pop_front();
        chk("err_out", err_out, e.exp_err);
        if (e.exact) begin
          chk("code_out", code_out, e.code);
        end else begin
          sum = 0;
          for (int k = 0; k < 12; k++) if (code_out[k]) sum += W_TAB[k];
          chk("decode", sum, e.data);
          chk("adjacent", code_out & (code_out >> 1), 0);
        end
        $display("out data=0x%02h code=0x%03h err=%0b", e.data, code_out, err_out);
      end
    end
  end

  task automatic accept(input logic [7:0] d, input logic e, input logic [11:0] c,
                        input logic ee, input bit exact);
    int n;
    vec_t v;
    n = 0;
    data_in  = d;
    err_in   = e;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready0 required=in_ready1");
    end else begin
      v.data = d; v.err = e; v.code = c; v.exp_err = ee; v.exact = exact;
      sb.push_back(v);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat, input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(name, lat, exp_lat);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_in = '0; err_in = 1'b0;

    vecs[0]  = '{8'h00, 1'b0, 12'h000, 1'b0, 1'b1};
    vecs[1]  = '{8'hFF, 1'b0, 12'h841, 1'b0, 1'b1};
    vecs[2]  = '{8'hFE, 1'b0, 12'h840, 1'b0, 1'b1};
    vecs[3]  = '{8'd100, 1'b0, 12'h214, 1'b0, 1'b1};
    vecs[4]  = '{8'hA5, 1'b1, 12'h0A5, 1'b1, 1'b1};
    vecs[5]  = '{8'd1, 1'b0, 12'h001, 1'b0, 1'b1};
    vecs[6]  = '{8'd2, 1'b0, 12'h002, 1'b0, 1'b1};
    vecs[7]  = '{8'd3, 1'b0, 12'h004, 1'b0, 1'b1};
    vecs[8]  = '{8'd4, 1'b0, 12'h005, 1'b0, 1'b1};
    vecs[9]  = '{8'd12, 1'b0, 12'h015, 1'b0, 1'b1};
    vecs[10] = '{8'd144, 1'b0, 12'h400, 1'b0, 1'b1};
    vecs[11] = '{8'd233, 1'b0, 12'h800, 1'b0, 1'b1};
    vecs[12] = '{8'h00, 1'b1, 12'h000, 1'b1, 1'b1};
    vecs[13] = '{8'hFF, 1'b1, 12'h0FF, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_code_out", code_out, 0);
    chk("rst_err_out", err_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector table; out_valid rises on the 22nd edge after acceptance, or on
    // the accepting edge itself for a bypassed word
    for (int i = 0; i < 14; i++) begin
      accept(vecs[i].data, vecs[i].err, vecs[i].code, vecs[i].exp_err, vecs[i].exact);
      if (!vecs[i].err) chk("busy_after_accept", busy, 1);
      wait_out(vecs[i].err ? LAT_BYP : LAT_ENC, "latency");
      @(posedge clk); #1;
    end

    // Exhaustive sweep checked by decoding and adjacency
    for (int d = 0; d < 256; d++) begin
      accept(8'(d), 1'b0, 12'h000, 1'b0, 1'b0);
      wait_out(LAT_ENC, "latency_sweep");
      @(posedge clk); #1;
    end

    // Consumer stalls in DONE: output held, no new word accepted
    out_ready = 1'b0;
    accept(8'd100, 1'b0, 12'h214, 1'b0, 1'b1);
    wait_out(LAT_ENC, "latency_hold");
    for (int i = 0; i < 5; i++) begin
      chk("hold_code", code_out, 12'h214);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      if (i == 2) begin data_in = 8'h33; err_in = 1'b0; in_valid = 1'b1; end
      if (i == 3) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("done_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("after_hold_in_ready", in_ready, 1);
    repeat (30) @(posedge clk);
    #1;
    chk("pulse_ignored_valid", out_valid, 0);
    chk("pulse_ignored_busy", busy, 0);

    // Reset in GEN (7th GEN cycle)
    accept(8'd200, 1'b0, 12'h501, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("gen_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    chk("rst_gen_in_ready", in_ready, 1);
    chk("rst_gen_valid", out_valid, 0);
    chk("rst_gen_code", code_out, 0);
    chk("rst_gen_busy", busy, 0);

    // Reset in ENC, after a codeword bit has already been set
    accept(8'd200, 1'b0, 12'h501, 1'b0, 1'b1);
    repeat (14) @(posedge clk);
    #1;
    chk("enc_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    chk("rst_enc_in_ready", in_ready, 1);
    chk("rst_enc_valid", out_valid, 0);
    chk("rst_enc_code", code_out, 0);
    chk("rst_enc_err", err_out, 0);
    repeat (25) @(posedge clk);
    #1;
    chk("rst_no_output", out_valid, 0);

    // A following word encodes correctly
    accept(8'd77, 1'b0, 12'h141, 1'b0, 1'b1);
    wait_out(LAT_ENC, "latency_after_rst");
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
